mem_access_block: RTL and testbench
===================================

// Module: mem_access_block
// PURPOSE
//   MEM-stage consumer of the EX/MEM pipeline register. Drives the data-memory bus with a
//   req/ack handshake and stalls the pipeline until the access completes.
//   Registers the MEM/WB stage. Produces WB_WriteData, the WB forwarding source for EX.
// PARAMETERS
//   DATA_W   32   data and address width
//   REG_W    5    register-specifier width
//   TIMEOUT  255  max ACCESS cycles without DMem_Ack before a bus error is raised (>=1)
// PORTS
//   Clock           in   1       processor clock; single clock domain
//   Reset           in   1       synchronous, active-high; clears all registers
//   MEM_ALUOut      in   DATA_W  ALU result / memory address from EX/MEM
//   MEM_RtData      in   DATA_W  store data from EX/MEM
//   MEM_DestReg     in   REG_W   destination register from EX/MEM
//   MEM_RegWrite    in   1       WB control from EX/MEM
//   MEM_MemtoReg    in   1       WB control from EX/MEM
//   MEM_MemRead     in   1       load request
//   MEM_MemWrite    in   1       store request
//   MEM_Instruction in   32      debug instruction word
//   DMem_Ack        in   1       memory completes the access this cycle
//   DMem_RData      in   DATA_W  load data; valid with DMem_Ack
//   DMem_Req        out  1       access request (registered)
//   DMem_We         out  1       1 = store, 0 = load (registered)
//   DMem_Addr       out  DATA_W  word-aligned address (registered)
//   DMem_WData      out  DATA_W  store data (registered)
//   MEM_Stall       out  1       hold PC, IF/ID, ID/EX and EX/MEM this cycle (combinational)
//   WB_ALUOut       out  DATA_W  MEM/WB ALU result
//   WB_ReadData     out  DATA_W  MEM/WB load data
//   WB_DestReg      out  REG_W   MEM/WB destination register
//   WB_RegWrite     out  1       MEM/WB register-write enable
//   WB_MemtoReg     out  1       MEM/WB write-data select
//   WB_Instruction  out  32      MEM/WB debug instruction word
//   WB_WriteData    out  DATA_W  WB_MemtoReg ? WB_ReadData : WB_ALUOut (combinational)
//   Misaligned      out  1       one-cycle pulse: memory op with MEM_ALUOut[1:0] != 0
//   BusError        out  1       one-cycle pulse: access timed out
// BEHAVIOUR
//   Reset: all registered outputs 0, FSM = IDLE, timeout counter = 0. Applies mid-ACCESS:
//     DMem_Req = 0 after the reset edge; the pending access is abandoned.
//   mem_op = MEM_MemRead | MEM_MemWrite. Both set at once is treated as a store.
//   IDLE:
//     - no mem_op: MEM_Stall = 0; MEM/WB captures inputs at the next edge (1-cycle latency).
//     - mem_op, aligned: MEM_Stall = 1; latch Addr/WData/We; DMem_Req <= 1; go to ACCESS.
//     - mem_op, misaligned: no request; Misaligned pulses; MEM_Stall = 0;
//       MEM/WB captures with WB_RegWrite = 0.
//   ACCESS:
//     - DMem_Req, DMem_Addr, DMem_WData and DMem_We are held stable.
//     - Count cycles spent in ACCESS.
//     - DMem_Ack = 1: MEM_Stall = 0; MEM/WB captures inputs, WB_ReadData <= DMem_RData
//       for a load; DMem_Req <= 0; counter cleared; go to IDLE.
//     - No ack, count == TIMEOUT: MEM_Stall = 0; BusError pulses; MEM/WB captures with
//       WB_RegWrite = 0; DMem_Req <= 0; go to IDLE.
//     - Otherwise: MEM_Stall = 1.
//   Stall cycles: MEM/WB loads a bubble (WB_RegWrite = 0, WB_MemtoReg = 0), so the
//     instruction writes back exactly once.
//   DMem_Ack in IDLE is ignored.
//   A memory op costs 1 + (ACCESS cycles up to and including the ack). Minimum is 2 cycles.
//   Store: WB_RegWrite follows MEM_RegWrite (0 for sw). WB_ReadData is unchanged on non-loads.
//   Pulse timing: Misaligned and BusError are registered and assert in the cycle after
//     the event.
// STRUCTURE
//   Shared package: FSM state constants (IDLE = 1'b0, ACCESS = 1'b1) and the
//     word-alignment mask.
//   One sub-module, mem_wb_stage: MEM/WB pipeline register with write and bubble inputs.
//   FSM, timeout counter ($clog2(TIMEOUT+1) bits) and bus registers live in the top module.
// TESTING
//   1 Reset held 2 cycles -> every output 0; DMem_Req = 0; MEM_Stall = 0.
//   2 ALU op ALUOut=0x1234, Dest=8, RegWrite=1 -> next cycle WB_WriteData=0x1234,
//     WB_DestReg=8, no stall.
//   3 lw addr 0x40, Ack in 3rd ACCESS cycle with RData=0xDEADBEEF -> MEM_Stall high 3 cycles;
//     DMem_Addr=0x40, DMem_We=0; then WB_WriteData=0xDEADBEEF.
//   4 sw addr 0x44, data 0xCAFE, Ack in 1st ACCESS cycle -> DMem_We=1, DMem_WData=0xCAFE;
//     1 stall cycle; WB_RegWrite=0.
//   5 lw addr 0x42 -> Misaligned pulse; DMem_Req never asserts; WB_RegWrite=0; no stall.
//   6 TIMEOUT=4, no Ack -> BusError pulse after the 4th ACCESS cycle; DMem_Req drops;
//     repeat with Reset mid-ACCESS -> DMem_Req=0 next cycle.

Source files
------------

// File: rtl/mem_access_block_pkg.sv
// Shared definitions for the MEM stage: access FSM states and word-alignment helpers.
package mem_access_block_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OFS_W   = 2;

  // Byte-offset bits that must be zero for a word access.
  localparam logic [OFS_W-1:0] WORD_OFS_MASK = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

  // True when the low address bits select a non-word-aligned byte.
  function automatic logic is_misaligned(input logic [OFS_W-1:0] ofs);
    return (ofs & WORD_OFS_MASK) != '0;
  endfunction

endpackage

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register.
//   clk, rst      : clock, synchronous active-high reset
//   write         : capture the MEM-stage fields this cycle
//   bubble        : insert a bubble (clear write-back controls, hold everything else)
//   load_en       : with write, also capture read_data
//   alu_out .. instruction      : MEM-stage fields to capture
//   wb_alu_out .. wb_instruction : registered MEM/WB fields
module mem_wb_stage
  import mem_access_block_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               write,
  input  logic               bubble,
  input  logic               load_en,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic [DATA_W-1:0]  read_data,
  input  logic [REG_W-1:0]   dest_reg,
  input  logic               reg_write,
  input  logic               mem_to_reg,
  input  logic [INSTR_W-1:0] instruction,
  output logic [DATA_W-1:0]  wb_alu_out,
  output logic [DATA_W-1:0]  wb_read_data,
  output logic [REG_W-1:0]   wb_dest_reg,
  output logic               wb_reg_write,
  output logic               wb_mem_to_reg,
  output logic [INSTR_W-1:0] wb_instruction
);

  // Capture has priority over bubble; read data only changes on a completed load.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_alu_out     <= '0;
      wb_read_data   <= '0;
      wb_dest_reg    <= '0;
      wb_reg_write   <= 1'b0;
      wb_mem_to_reg  <= 1'b0;
      wb_instruction <= '0;
    end else if (write) begin
      wb_alu_out     <= alu_out;
      wb_dest_reg    <= dest_reg;
      wb_reg_write   <= reg_write;
      wb_mem_to_reg  <= mem_to_reg;
      wb_instruction <= instruction;
      if (load_en) begin
        wb_read_data <= read_data;
      end
    end else if (bubble) begin
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_access_block.sv
// MEM stage: issues data-memory requests with a req/ack handshake, stalls the
// pipeline while an access is outstanding, times out hung accesses, and feeds
// the MEM/WB register.
//   Clock, Reset          : clock, synchronous active-high reset
//   MEM_*                 : EX/MEM pipeline fields
//   DMem_Ack, DMem_RData  : memory completion and load data
//   DMem_Req/We/Addr/WData: registered memory request
//   MEM_Stall             : combinational stall to upstream stages
//   WB_*                  : MEM/WB fields; WB_WriteData is the combinational write-back value
//   Misaligned, BusError  : one-cycle registered event pulses
module mem_access_block
  import mem_access_block_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [DATA_W-1:0]  MEM_ALUOut,
  input  logic [DATA_W-1:0]  MEM_RtData,
  input  logic [REG_W-1:0]   MEM_DestReg,
  input  logic               MEM_RegWrite,
  input  logic               MEM_MemtoReg,
  input  logic               MEM_MemRead,
  input  logic               MEM_MemWrite,
  input  logic [INSTR_W-1:0] MEM_Instruction,
  input  logic               DMem_Ack,
  input  logic [DATA_W-1:0]  DMem_RData,
  output logic               DMem_Req,
  output logic               DMem_We,
  output logic [DATA_W-1:0]  DMem_Addr,
  output logic [DATA_W-1:0]  DMem_WData,
  output logic               MEM_Stall,
  output logic [DATA_W-1:0]  WB_ALUOut,
  output logic [DATA_W-1:0]  WB_ReadData,
  output logic [REG_W-1:0]   WB_DestReg,
  output logic               WB_RegWrite,
  output logic               WB_MemtoReg,
  output logic [INSTR_W-1:0] WB_Instruction,
  output logic [DATA_W-1:0]  WB_WriteData,
  output logic               Misaligned,
  output logic               BusError
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  mem_state_e       state;
  logic [CNT_W-1:0] cnt;  // number of the current ACCESS cycle (1-based), 0 in IDLE

  logic mem_op;
  logic misaligned_op;
  logic start;
  logic done_ack;
  logic done_timeout;
  logic misaligned_ev;
  logic wb_write;
  logic wb_bubble;
  logic wb_load;
  logic wb_reg_write;

  assign mem_op        = MEM_MemRead | MEM_MemWrite;
  assign misaligned_op = is_misaligned(MEM_ALUOut[OFS_W-1:0]);

  // Per-cycle decisions: stall, MEM/WB control and FSM events.
  always_comb begin
    MEM_Stall     = 1'b0;
    start         = 1'b0;
    done_ack      = 1'b0;
    done_timeout  = 1'b0;
    misaligned_ev = 1'b0;
    wb_write      = 1'b0;
    wb_bubble     = 1'b0;
    wb_load       = 1'b0;
    wb_reg_write  = MEM_RegWrite;
    if (state == IDLE) begin
      if (!mem_op) begin
        wb_write = 1'b1;
      end else if (misaligned_op) begin
        misaligned_ev = 1'b1;
        wb_write      = 1'b1;
        wb_reg_write  = 1'b0;
      end else begin
        start     = 1'b1;
        MEM_Stall = 1'b1;
        wb_bubble = 1'b1;
      end
    end else begin
      if (DMem_Ack) begin
        done_ack = 1'b1;
        wb_write = 1'b1;
        wb_load  = ~DMem_We;
      end else if (cnt == CNT_W'(TIMEOUT)) begin
        done_timeout = 1'b1;
        wb_write     = 1'b1;
        wb_reg_write = 1'b0;
      end else begin
        MEM_Stall = 1'b1;
        wb_bubble = 1'b1;
      end
    end
  end

  // FSM, timeout counter, bus request registers and event pulses.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      DMem_Req   <= 1'b0;
      DMem_We    <= 1'b0;
      DMem_Addr  <= '0;
      DMem_WData <= '0;
      Misaligned <= 1'b0;
      BusError   <= 1'b0;
    end else begin
      Misaligned <= misaligned_ev;
      BusError   <= done_timeout;
      if (start) begin
        state      <= ACCESS;
        cnt        <= CNT_W'(1);
        DMem_Req   <= 1'b1;
        // A simultaneous read+write request is issued as a store.
        DMem_We    <= MEM_MemWrite;
        DMem_Addr  <= {MEM_ALUOut[DATA_W-1:OFS_W], {OFS_W{1'b0}}};
        DMem_WData <= MEM_RtData;
      end else if (done_ack || done_timeout) begin
        state    <= IDLE;
        cnt      <= '0;
        DMem_Req <= 1'b0;
      end else if (state == ACCESS) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  mem_wb_stage #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_mem_wb (
    .clk            (Clock),
    .rst            (Reset),
    .write          (wb_write),
    .bubble         (wb_bubble),
    .load_en        (wb_load),
    .alu_out        (MEM_ALUOut),
    .read_data      (DMem_RData),
    .dest_reg       (MEM_DestReg),
    .reg_write      (wb_reg_write),
    .mem_to_reg     (MEM_MemtoReg),
    .instruction    (MEM_Instruction),
    .wb_alu_out     (WB_ALUOut),
    .wb_read_data   (WB_ReadData),
    .wb_dest_reg    (WB_DestReg),
    .wb_reg_write   (WB_RegWrite),
    .wb_mem_to_reg  (WB_MemtoReg),
    .wb_instruction (WB_Instruction)
  );

  assign WB_WriteData = WB_MemtoReg ? WB_ReadData : WB_ALUOut;

endmodule

// File: tb/tb_mem_access_block.sv
// Bench for mem_access_block: directed cases plus randomized instructions,
// checked against a transaction-level model of cost, stall and write-back.
module tb_mem_access_block;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned TO     = 4;

  logic              Clock;
  logic              Reset;
  logic [DATA_W-1:0] MEM_ALUOut;
  logic [DATA_W-1:0] MEM_RtData;
  logic [REG_W-1:0]  MEM_DestReg;
  logic              MEM_RegWrite;
  logic              MEM_MemtoReg;
  logic              MEM_MemRead;
  logic              MEM_MemWrite;
  logic [31:0]       MEM_Instruction;
  logic              DMem_Ack;
  logic [DATA_W-1:0] DMem_RData;
  logic              DMem_Req;
  logic              DMem_We;
  logic [DATA_W-1:0] DMem_Addr;
  logic [DATA_W-1:0] DMem_WData;
  logic              MEM_Stall;
  logic [DATA_W-1:0] WB_ALUOut;
  logic [DATA_W-1:0] WB_ReadData;
  logic [REG_W-1:0]  WB_DestReg;
  logic              WB_RegWrite;
  logic              WB_MemtoReg;
  logic [31:0]       WB_Instruction;
  logic [DATA_W-1:0] WB_WriteData;
  logic              Misaligned;
  logic              BusError;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Model state: last load data written into MEM/WB.
  logic [DATA_W-1:0] exp_rd = '0;

  mem_access_block #(
    .DATA_W  (DATA_W),
    .REG_W   (REG_W),
    .TIMEOUT (TO)
  ) dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .MEM_ALUOut      (MEM_ALUOut),
    .MEM_RtData      (MEM_RtData),
    .MEM_DestReg     (MEM_DestReg),
    .MEM_RegWrite    (MEM_RegWrite),
    .MEM_MemtoReg    (MEM_MemtoReg),
    .MEM_MemRead     (MEM_MemRead),
    .MEM_MemWrite    (MEM_MemWrite),
    .MEM_Instruction (MEM_Instruction),
    .DMem_Ack        (DMem_Ack),
    .DMem_RData      (DMem_RData),
    .DMem_Req        (DMem_Req),
    .DMem_We         (DMem_We),
    .DMem_Addr       (DMem_Addr),
    .DMem_WData      (DMem_WData),
    .MEM_Stall       (MEM_Stall),
    .WB_ALUOut       (WB_ALUOut),
    .WB_ReadData     (WB_ReadData),
    .WB_DestReg      (WB_DestReg),
    .WB_RegWrite     (WB_RegWrite),
    .WB_MemtoReg     (WB_MemtoReg),
    .WB_Instruction  (WB_Instruction),
    .WB_WriteData    (WB_WriteData),
    .Misaligned      (Misaligned),
    .BusError        (BusError)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_idle_inputs();
    MEM_ALUOut      = '0;
    MEM_RtData      = '0;
    MEM_DestReg     = '0;
    MEM_RegWrite    = 1'b0;
    MEM_MemtoReg    = 1'b0;
    MEM_MemRead     = 1'b0;
    MEM_MemWrite    = 1'b0;
    MEM_Instruction = '0;
    DMem_Ack        = 1'b0;
    DMem_RData      = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},   64'(DMem_Req), 64'd0);
    check({tag, "_we"},    64'(DMem_We), 64'd0);
    check({tag, "_addr"},  64'(DMem_Addr), 64'd0);
    check({tag, "_wdata"}, 64'(DMem_WData), 64'd0);
    check({tag, "_stall"}, 64'(MEM_Stall), 64'd0);
    check({tag, "_wbalu"}, 64'(WB_ALUOut), 64'd0);
    check({tag, "_wbrd"},  64'(WB_ReadData), 64'd0);
    check({tag, "_wbdst"}, 64'(WB_DestReg), 64'd0);
    check({tag, "_wbrw"},  64'(WB_RegWrite), 64'd0);
    check({tag, "_wbm2r"}, 64'(WB_MemtoReg), 64'd0);
    check({tag, "_wbins"}, 64'(WB_Instruction), 64'd0);
    check({tag, "_wbwd"},  64'(WB_WriteData), 64'd0);
    check({tag, "_mis"},   64'(Misaligned), 64'd0);
    check({tag, "_berr"},  64'(BusError), 64'd0);
  endtask

  // Present one EX/MEM instruction at a negedge and follow it to write-back.
  // lat = ACCESS cycle in which memory acks; lat > TO means it never acks.
  task automatic run_instr(input string tag, input logic [31:0] alu, input logic [31:0] rt,
                           input logic [4:0] dest, input logic rw, input logic m2r,
                           input logic mr, input logic mw, input logic [31:0] ins,
                           input int unsigned lat, input logic [31:0] rdata);
    logic mem_op, mis, tmo, is_load;
    int unsigned cycles;
    mem_op  = mr | mw;
    mis     = mem_op && (alu[1:0] != 2'b00);
    is_load = mr && !mw;
    tmo     = 1'b0;
    if (!mem_op || mis) cycles = 1;
    else if (lat <= TO) cycles = 1 + lat;
    else begin
      cycles = 1 + TO;
      tmo    = 1'b1;
    end

    MEM_ALUOut = alu; MEM_RtData = rt; MEM_DestReg = dest; MEM_RegWrite = rw;
    MEM_MemtoReg = m2r; MEM_MemRead = mr; MEM_MemWrite = mw; MEM_Instruction = ins;

    for (int c = 0; c < int'(cycles); c++) begin
      if (c == 0) begin
        // An ack while idle must be ignored.
        DMem_Ack   = 1'($urandom_range(0, 1));
        DMem_RData = $urandom;
      end else begin
        DMem_Ack   = (c == int'(lat));
        DMem_RData = (c == int'(lat)) ? rdata : $urandom;
      end
      #1;
      check({tag, "_stall"}, 64'(MEM_Stall), 64'(c < int'(cycles) - 1));
      if (c == 0) begin
        check({tag, "_req0"}, 64'(DMem_Req), 64'd0);
      end else begin
        check({tag, "_req"},   64'(DMem_Req), 64'd1);
        check({tag, "_addr"},  64'(DMem_Addr), 64'(alu));
        check({tag, "_we"},    64'(DMem_We), 64'(mw));
        check({tag, "_wdata"}, 64'(DMem_WData), 64'(rt));
        check({tag, "_bub"},   64'({WB_RegWrite, WB_MemtoReg}), 64'd0);
        check({tag, "_nopls"}, 64'({Misaligned, BusError}), 64'd0);
      end
      @(negedge Clock);
    end
    DMem_Ack = 1'b0;

    if (mem_op && !mis && !tmo && is_load) exp_rd = rdata;
    check({tag, "_wbrw"},  64'(WB_RegWrite), 64'(rw && !mis && !tmo));
    check({tag, "_wbm2r"}, 64'(WB_MemtoReg), 64'(m2r));
    check({tag, "_wbdst"}, 64'(WB_DestReg), 64'(dest));
    check({tag, "_wbalu"}, 64'(WB_ALUOut), 64'(alu));
    check({tag, "_wbins"}, 64'(WB_Instruction), 64'(ins));
    check({tag, "_wbrd"},  64'(WB_ReadData), 64'(exp_rd));
    check({tag, "_wbwd"},  64'(WB_WriteData), 64'(m2r ? exp_rd : alu));
    check({tag, "_mis"},   64'(Misaligned), 64'(mis));
    check({tag, "_berr"},  64'(BusError), 64'(tmo));
    check({tag, "_reqend"}, 64'(DMem_Req), 64'd0);
  endtask

  initial begin
    logic [31:0] alu;
    logic        mr, mw;
    int unsigned sel;

    drive_idle_inputs();
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check_all_zero("reset");
    Reset = 1'b0;

    // Plain ALU op: one-cycle pass-through.
    run_instr("alu", 32'h0000_1234, 32'h5555_0000, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0100_0001, 0, '0);
    // Load acked in its third ACCESS cycle.
    run_instr("lw", 32'h0000_0040, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 32'h8C09_0040, 3, 32'hDEAD_BEEF);
    // Store acked in its first ACCESS cycle.
    run_instr("sw", 32'h0000_0044, 32'h0000_CAFE, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hAC0A_0044, 1, '0);
    // Misaligned load: no request, no write-back.
    run_instr("mis", 32'h0000_0042, 32'h0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 32'h8C03_0042, 1, 32'h1111_1111);
    // Load that never gets acked.
    run_instr("tmo", 32'h0000_0080, 32'h0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 32'h8C04_0080, TO + 1, '0);
    // Read and write together behave as a store.
    run_instr("rdwr", 32'h0000_0100, 32'h0BAD_F00D, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 32'hAC05_0100, 2, 32'h2222_2222);

    // Reset while an access is outstanding.
    MEM_ALUOut = 32'h0000_0200; MEM_DestReg = 5'd6; MEM_RegWrite = 1'b1;
    MEM_MemtoReg = 1'b1; MEM_MemRead = 1'b1; MEM_MemWrite = 1'b0; MEM_Instruction = 32'h8C06_0200;
    DMem_Ack = 1'b0;
    repeat (2) @(negedge Clock);
    #1;
    check("rstmid_reqpre", 64'(DMem_Req), 64'd1);
    check("rstmid_stallpre", 64'(MEM_Stall), 64'd1);
    Reset = 1'b1;
    drive_idle_inputs();
    @(negedge Clock);
    check_all_zero("rstmid");
    exp_rd = '0;
    Reset = 1'b0;
    run_instr("post_rst", 32'h0000_0300, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 32'h8C07_0300, 2, 32'h7777_7777);

    // Random instruction stream.
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      mr  = (sel >= 4 && sel <= 6) || sel == 9;
      mw  = sel >= 7;
      alu = $urandom;
      if (mr || mw) begin
        if ($urandom_range(0, 5) != 0) alu[1:0] = 2'b00;
        else alu[1:0] = 2'($urandom_range(1, 3));
      end
      run_instr("rnd", alu, $urandom, 5'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), mr, mw, $urandom,
                $urandom_range(1, TO + 2), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
